// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I ALU-class instructions into ALU select/operands and holds them in an ID/EX register.
// Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module alu_issue_stage #(
    parameter int DATA_LEN  = 32,
    parameter int SEL_LEN   = 4,
    parameter int SHAMT_LEN = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic [DATA_LEN-1:0] pc,
    input  logic [DATA_LEN-1:0] rs1_data,
    input  logic [DATA_LEN-1:0] rs2_data,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [SEL_LEN-1:0]  ex_alu_sel,
    output logic [DATA_LEN-1:0] ex_src1,
    output logic [DATA_LEN-1:0] ex_src2,
    output logic [4:0]          ex_rd,
    output logic                ex_reg_write,
    output logic                ex_illegal
);
    localparam int PAY_LEN = SEL_LEN + 2 * DATA_LEN + 7;

    logic [6:0]          w_op;
    logic [2:0]          w_f3;
    logic [6:0]          w_f7;
    logic                w_legal;
    logic [SEL_LEN-1:0]  w_sel;
    logic [DATA_LEN-1:0] w_src1;
    logic [DATA_LEN-1:0] w_src2;
    logic [DATA_LEN-1:0] w_iimm;
    logic [DATA_LEN-1:0] w_uimm;
    logic [DATA_LEN-1:0] w_shamt;
    logic [PAY_LEN-1:0]  w_pay;
    logic [PAY_LEN-1:0]  r_pay;
    logic                r_valid;
    logic                w_acc;

    assign w_op    = instr[6:0];
    assign w_f3    = instr[14:12];
    assign w_f7    = instr[31:25];
    assign w_iimm  = DATA_LEN'($signed(instr[31:20]));
    assign w_uimm  = DATA_LEN'($signed({instr[31:12], 12'b0}));
    assign w_shamt = DATA_LEN'(instr[20 +: SHAMT_LEN]);

    // alt selects SUB/SRA; callers only raise it where that variant is legal
    function automatic logic [SEL_LEN-1:0] f3_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? SEL_LEN'(1) : SEL_LEN'(0);
            3'b001:  return SEL_LEN'(7);
            3'b010:  return SEL_LEN'(5);
            3'b011:  return SEL_LEN'(6);
            3'b100:  return SEL_LEN'(4);
            3'b101:  return alt ? SEL_LEN'(9) : SEL_LEN'(8);
            3'b110:  return SEL_LEN'(3);
            default: return SEL_LEN'(2);
        endcase
    endfunction

    always_comb begin
        w_legal = 1'b0;
        w_sel   = '0;
        w_src1  = rs1_data;
        w_src2  = rs2_data;
        case (w_op)
            7'b0110011: begin
                w_legal = w_f7 == 7'b0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101));
                w_sel   = f3_sel(w_f3, w_f7[5]);
            end
            7'b0010011: begin
                w_legal = w_f3 == 3'b001 ? w_f7 == 7'b0 :
                          w_f3 == 3'b101 ? (w_f7 == 7'b0 || w_f7 == 7'b0100000) : 1'b1;
                w_sel   = f3_sel(w_f3, w_f3 == 3'b101 && w_f7[5]);
                w_src2  = w_f3[1:0] == 2'b01 ? w_shamt : w_iimm;
            end
            7'b0110111: begin
                w_legal = 1'b1;
                w_src1  = '0;
                w_src2  = w_uimm;
            end
            7'b0010111: begin
                w_legal = 1'b1;
                w_src1  = pc;
                w_src2  = w_uimm;
            end
            default: ;
        endcase
        if (!w_legal) begin
            w_sel  = '0;
            w_src1 = '0;
            w_src2 = '0;
        end
    end

    assign w_pay = {w_sel, w_src1, w_src2, instr[11:7], w_legal && instr[11:7] != 5'd0, !w_legal};
    assign {ex_alu_sel, ex_src1, ex_src2, ex_rd, ex_reg_write, ex_illegal} = r_pay;
    assign ex_valid = r_valid;

`ifdef ALU_ISSUE_SKID_EN
    logic               r_sk_valid;
    logic               r_in_ready;
    logic [PAY_LEN-1:0] r_sk_pay;
    logic               w_free;
    logic               w_sk_next;

    assign in_ready  = r_in_ready;
    assign w_acc     = in_valid & r_in_ready & !flush;
    assign w_free    = !r_valid | ex_ready;
    assign w_sk_next = w_free ? (r_sk_valid & w_acc) : (r_sk_valid | w_acc);

    // skid entry always holds the younger op; it refills the output register first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pay      <= '0;
            r_sk_valid <= 1'b0;
            r_sk_pay   <= '0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_sk_valid <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_sk_valid <= w_sk_next;
            r_in_ready <= !w_sk_next;
            if (w_free) begin
                r_valid <= r_sk_valid | w_acc;
                if (r_sk_valid)
                    r_pay <= r_sk_pay;
                else if (w_acc)
                    r_pay <= w_pay;
            end
            if (w_acc && (r_sk_valid || !w_free))
                r_sk_pay <= w_pay;
        end
    end
`else
    assign in_ready = !r_valid | ex_ready;
    assign w_acc    = in_valid & in_ready & !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pay   <= '0;
        end else begin
            r_valid <= !flush && (w_acc || (r_valid && !ex_ready));
            if (w_acc)
                r_pay <= w_pay;
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed stimulus with a scoreboard of expected issued ops for alu_issue_stage.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        ex_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        in_ready;
    logic        ex_valid;
    logic [3:0]  ex_alu_sel;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_illegal;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    exp_t e_m;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_sel(ex_alu_sel),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic wr, input logic ill);
        return exp_t'({s, a, b, rd, wr, ill});
    endfunction

    // transfers are judged at the falling edge, half a cycle before the edge that commits them
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush)
                q.delete();
            else begin
                if (ex_valid && ex_ready) begin
                    if (q.size() == 0)
                        chk("unexpected_out", 32'(ex_valid), 32'd0);
                    else begin
                        e_m = q.pop_front();
                        chk("sel", 32'(ex_alu_sel), 32'(e_m.sel));
                        chk("src1", ex_src1, e_m.s1);
                        chk("src2", ex_src2, e_m.s2);
                        chk("rd", 32'(ex_rd), 32'(e_m.rd));
                        chk("reg_write", 32'(ex_reg_write), 32'(e_m.wr));
                        chk("illegal", 32'(ex_illegal), 32'(e_m.ill));
                    end
                end
                if (in_valid && in_ready)
                    q.push_back(pend);
            end
        end
    end

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
        instr = i;
        pc = p;
        rs1_data = a;
        rs2_data = b;
        pend = e;
        in_valid = 1'b1;
    endtask

    task automatic wait_acc(input string tag);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk({tag, "_accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input string tag, input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
        drive(i, p, a, b, e);
        wait_acc(tag);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
        @(posedge clk);
        #1;
        chk({tag, "_q_empty"}, 32'(q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(ex_valid), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_sel"}, 32'(ex_alu_sel), 32'd0);
        chk({tag, "_src1"}, ex_src1, 32'd0);
        chk({tag, "_src2"}, ex_src2, 32'd0);
        chk({tag, "_rd"}, 32'(ex_rd), 32'd0);
        chk({tag, "_wr"}, 32'(ex_reg_write), 32'd0);
        chk({tag, "_ill"}, 32'(ex_illegal), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);

        ex_ready = 1'b1;
        send("sub", 32'h40208133, 32'h0, 32'd10, 32'd3, mk(4'd1, 32'd10, 32'd3, 5'd2, 1'b1, 1'b0));
        chk("latency", 32'(ex_valid), 32'd1);
        send("slti", 32'hFFF0A093, 32'h0, 32'd7, 32'd99, mk(4'd5, 32'd7, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0));
        send("srai", 32'h4030D093, 32'h0, 32'h80000000, 32'd99, mk(4'd9, 32'h80000000, 32'd3, 5'd1, 1'b1, 1'b0));
        send("auipc", 32'h12345297, 32'h100, 32'd1, 32'd2, mk(4'd0, 32'h100, 32'h12345000, 5'd5, 1'b1, 1'b0));
        send("lui_x0", 32'h00001037, 32'h0, 32'd1, 32'd2, mk(4'd0, 32'd0, 32'h1000, 5'd0, 1'b0, 1'b0));
        send("and", 32'h0020F1B3, 32'h0, 32'hF0F0, 32'hFF00, mk(4'd2, 32'hF0F0, 32'hFF00, 5'd3, 1'b1, 1'b0));
        send("mul_ill", 32'h022081B3, 32'h40, 32'd5, 32'd6, mk(4'd0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1));
        send("slli_ill", 32'h40209093, 32'h0, 32'd5, 32'd6, mk(4'd0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1));
        send("lw_ill", 32'h0000A083, 32'h0, 32'd5, 32'd6, mk(4'd0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1));
        drain("b2b");

        ex_ready = 1'b0;
        send("stall_a", 32'h002081B3, 32'h0, 32'd5, 32'd6, mk(4'd0, 32'd5, 32'd6, 5'd3, 1'b1, 1'b0));
        drive(32'h0020C233, 32'h0, 32'hF0, 32'hFF, mk(4'd4, 32'hF0, 32'hFF, 5'd4, 1'b1, 1'b0));
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(ex_valid), 32'd1);
            chk("stall_src1", ex_src1, 32'd5);
            chk("stall_src2", ex_src2, 32'd6);
            chk("stall_rd", 32'(ex_rd), 32'd3);
        end
        @(posedge clk);
        #1;
        ex_ready = 1'b1;
        wait_acc("stall_b");
        send("stall_c", 32'h0020E2B3, 32'h0, 32'd1, 32'd2, mk(4'd3, 32'd1, 32'd2, 5'd5, 1'b1, 1'b0));
        drain("stall");

        ex_ready = 1'b0;
        send("flush_d", 32'h40208333, 32'h0, 32'd9, 32'd4, mk(4'd1, 32'd9, 32'd4, 5'd6, 1'b1, 1'b0));
        drive(32'h002083B3, 32'h0, 32'd1, 32'd1, mk(4'd0, 32'd1, 32'd1, 5'd7, 1'b1, 1'b0));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_held_valid", 32'(ex_valid), 32'd0);
        ex_ready = 1'b1;
        drive(32'h002083B3, 32'h0, 32'd1, 32'd1, mk(4'd0, 32'd1, 32'd1, 5'd7, 1'b1, 1'b0));
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_drop_valid", 32'(ex_valid), 32'd0);
        drain("flush");

        ex_ready = 1'b0;
        send("rst_f", 32'hFFF0A093, 32'h0, 32'd3, 32'd0, mk(4'd5, 32'd3, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0));
        chk("rst_f_valid", 32'(ex_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_ex_valid", 32'(ex_valid), 32'd0);
        ex_ready = 1'b1;
        send("post_rst", 32'hABCDE4B7, 32'h0, 32'd1, 32'd2, mk(4'd0, 32'd0, 32'hABCDE000, 5'd9, 1'b1, 1'b0));
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered decode-and-issue stage that feeds the ALU.
- Decodes an RV32I ALU-class instruction (OP, OP-IMM, LUI, AUIPC) into ALU_sel and the two ALU operands, then holds them in an ID/EX register.
- Uses a valid/ready handshake on both sides. Supports flush.
- Sits between the register-file read and the ALU. Lets the core move from single-cycle to a staged datapath without changing the ALU.

Parameters:
- DATA_LEN, 32, operand/PC width (equals ALU data width).
- SEL_LEN, 4, ALU_sel width.
- SHAMT_LEN, 5, shift-amount width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; drops held and incoming instruction.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- instr  in  32  instruction word.
- pc  in  DATA_LEN  instruction address.
- rs1_data  in  DATA_LEN  register-file read 1.
- rs2_data  in  DATA_LEN  register-file read 2.
- ex_valid  out  1  issued op valid.
- ex_ready  in  1  ALU/EX consumer accepts.
- ex_alu_sel  out  SEL_LEN  ALU operation.
- ex_src1  out  DATA_LEN  ALU operand 1.
- ex_src2  out  DATA_LEN  ALU operand 2.
- ex_rd  out  5  destination register.
- ex_reg_write  out  1  write-back enable.
- ex_illegal  out  1  instruction not ALU-class or malformed.

Behaviour:
- Reset (rst_n=0, asynchronous): every ex_* output is 0 (ex_alu_sel=ADD=0). in_ready is 1 after reset.
- ALU_sel encoding (shared with ALU): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when ex_valid & ex_ready.
  - in_ready = !ex_valid | ex_ready.
  - Outputs are stable while ex_valid & !ex_ready.
- Latency: 1 cycle from accepted input to ex_valid. Back-to-back throughput is 1 per cycle when ex_ready=1.
- Decode:
  - OP (0110011):
    - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - funct7=0100000: funct3 000 SUB, 101 SRA.
    - Any other funct7/funct3 combination is illegal.
    - src1=rs1_data, src2=rs2_data.
  - OP-IMM (0010011): same funct3 map, no SUB. src1=rs1_data, src2=sign-extended I-imm.
    - 001 requires funct7=0000000.
    - 101 requires funct7 0000000 (SRL) or 0100000 (SRA).
    - For shifts, src2 = zero-extended instr[24:20].
  - LUI (0110111): ADD, src1=0, src2={instr[31:12],12'b0}.
  - AUIPC (0010111): ADD, src1=pc, src2=U-imm.
  - Anything else is illegal.
- Illegal: ex_illegal=1, ex_alu_sel=ADD, src1=src2=0, ex_reg_write=0, ex_rd=instr[11:7]. Illegal ops still handshake normally.
- ex_reg_write = legal & (rd != 0).
- Flush:
  - Clears ex_valid next edge regardless of ex_ready.
  - An input offered in the same cycle is discarded (not accepted into the stage).
  - in_ready follows the normal rule.
- Simultaneous drain+fill (ex_valid & ex_ready & in_valid): the new op is loaded, ex_valid stays 1.
- Reset mid-stall: ex_valid drops immediately and the held op is lost.

Optional Feature:
- Macro ALU_ISSUE_SKID_EN.
- Defined:
  - 2-entry skid buffer.
  - in_ready is a register output (no combinational path from ex_ready).
  - in_ready=0 only when both entries are full.
  - Order is preserved.
  - Flush empties both entries.
  - Latency is still 1 cycle when empty.
- Undefined: single register, combinational in_ready as above.

Test Plan:
- Reset with rst_n=0 mid-stream -> all ex_* = 0 immediately; after release in_ready=1, ex_valid=0.
- instr=0x40208133 (sub x2,x1,x2), rs1=10, rs2=3, ex_ready=1 -> next cycle ex_valid=1, sel=1, src1=10, src2=3, rd=2, reg_write=1.
- instr=0xFFF0A093 (slti x1,x1,-1) -> sel=5, src2=0xFFFFFFFF. instr=0x4030D093 (srai x1,x1,3) -> sel=9, src2=3.
- auipc x5,0x12345 at pc=0x100 -> sel=0, src1=0x100, src2=0x12345000. lui x0,1 -> reg_write=0.
- ex_ready=0 for 3 cycles with in_valid=1 -> outputs frozen, in_ready=0 (skid build: two ops buffered, then in_ready=0); release -> ops emerge in order, none lost or duplicated.
- Load opcode 0000011 -> ex_illegal=1, reg_write=0. Flush with ex_valid=1, ex_ready=0 -> ex_valid=0 next cycle, and the op offered in the flush cycle never appears.
